// File: rtl/road_renderer_pkg.sv
// Shared types and constants for the road renderer and its VGA driver.
package road_pkg;
    typedef enum logic [1:0] {IDLE, RUN, CRASH} state_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t C_BLACK  = 12'h000;
    localparam rgb_t C_RED    = 12'hF00;
    localparam rgb_t C_YELLOW = 12'hFF0;
    localparam rgb_t C_WHITE  = 12'hFFF;
    localparam rgb_t C_ROAD   = 12'h666;
    localparam rgb_t C_GRASS  = 12'h080;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
endpackage

// File: rtl/road_renderer_btn_sync.sv
// Two-flop synchroniser for a bundle of asynchronous button inputs.
module btn_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/road_renderer.sv
// Road Fighter pixel generator: per-frame game FSM plus a 1-clk registered colour mux.
module road_renderer
    import road_pkg::*;
#(
    parameter int WIDTH        = 10,
    parameter int HACTIVE      = H_ACTIVE,
    parameter int VACTIVE      = V_ACTIVE,
    parameter int ROAD_L       = 200,
    parameter int ROAD_R       = 440,
    parameter int EDGE_W       = 4,
    parameter int CAR_W        = 32,
    parameter int CAR_H        = 48,
    parameter int CAR_Y        = 400,
    parameter int STEP         = 4,
    parameter int DASH_P       = 64,
    parameter int CRASH_FRAMES = 60
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] hor_pix,
    input  logic [WIDTH-1:0] ver_pix,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_start,
    input  logic [1:0]       speed,
    output logic [3:0]       vgaRed,
    output logic [3:0]       vgaGreen,
    output logic [3:0]       vgaBlue,
    output logic             frame_tick,
    output logic             crash
);
    localparam int XW = WIDTH + 1;
    localparam int DW = $clog2(DASH_P);
    localparam int CW = $clog2(CRASH_FRAMES);

    localparam logic [XW-1:0] CENTRE  = XW'((ROAD_L + ROAD_R - CAR_W) / 2);
    localparam logic [XW-1:0] DASH_LO = XW'((ROAD_L + ROAD_R) / 2 - 1);
    localparam logic [XW-1:0] DASH_HI = XW'((ROAD_L + ROAD_R) / 2 + 1);
    localparam logic [XW-1:0] RL_X    = XW'(ROAD_L);
    localparam logic [XW-1:0] RR_X    = XW'(ROAD_R);
    localparam logic [XW-1:0] EL_X    = XW'(ROAD_L + EDGE_W);
    localparam logic [XW-1:0] ER_X    = XW'(ROAD_R - EDGE_W);
    localparam logic [XW-1:0] CARW_X  = XW'(CAR_W);
    localparam logic [XW-1:0] CARY_X  = XW'(CAR_Y);
    localparam logic [XW-1:0] CARYE_X = XW'(CAR_Y + CAR_H);
    localparam logic [XW-1:0] STEP_X  = XW'(STEP);
    localparam logic [XW-1:0] XMAX    = XW'(HACTIVE - CAR_W);
    localparam logic [XW-1:0] HACT_X  = XW'(HACTIVE);
    localparam logic [XW-1:0] VACT_X  = XW'(VACTIVE);

    logic [2:0] btn_s;
    logic       btn_l, btn_r, btn_st;

    btn_sync #(.W(3)) u_btn_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({btn_start, btn_right, btn_left}),
        .q     (btn_s)
    );
    assign {btn_st, btn_r, btn_l} = btn_s;

    state_t             state, state_nx;
    logic [DW-1:0]      scroll, scroll_nx;
    logic [WIDTH-1:0]   car_x, car_x_nx;
    logic [CW-1:0]      crash_cnt, crash_cnt_nx;
    logic [XW-1:0]      x, y, cx, next_x;
    logic               tick_cond, off_road;

    assign x         = {1'b0, hor_pix};
    assign y         = {1'b0, ver_pix};
    assign cx        = {1'b0, car_x};
    assign tick_cond = (x == '0) && (y == VACT_X);

    // Clamp arithmetic is one bit wider than the counters so it never wraps.
    always_comb begin
        next_x = cx;
        if (btn_l && !btn_r)
            next_x = (cx >= STEP_X) ? cx - STEP_X : '0;
        else if (btn_r && !btn_l)
            next_x = (cx + STEP_X > XMAX) ? XMAX : cx + STEP_X;
    end
    assign off_road = (next_x < RL_X) || (next_x + CARW_X > RR_X);

    always_comb begin
        state_nx     = state;
        scroll_nx    = scroll;
        car_x_nx     = car_x;
        crash_cnt_nx = crash_cnt;
        if (tick_cond) begin
            case (state)
                IDLE: if (btn_st) begin
                    state_nx  = RUN;
                    car_x_nx  = CENTRE[WIDTH-1:0];
                    scroll_nx = '0;
                end
                RUN: begin
                    scroll_nx = scroll + DW'({speed, 1'b0});
                    car_x_nx  = next_x[WIDTH-1:0];
                    if (off_road) begin
                        state_nx     = CRASH;
                        crash_cnt_nx = '0;
                    end
                end
                CRASH: if (crash_cnt == CW'(CRASH_FRAMES - 1)) begin
                    state_nx  = IDLE;
                    car_x_nx  = CENTRE[WIDTH-1:0];
                    scroll_nx = '0;
                end else begin
                    crash_cnt_nx = crash_cnt + CW'(1);
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    logic          in_act, in_car, in_dash, in_edge, in_road;
    logic [DW-1:0] dy;
    rgb_t          pix, pix_q;

    assign dy      = ver_pix[DW-1:0] - scroll;
    assign in_act  = (x < HACT_X) && (y < VACT_X);
    assign in_car  = (x >= cx) && (x < cx + CARW_X) && (y >= CARY_X) && (y < CARYE_X)
                     && !(state == CRASH && crash_cnt[3]);
    assign in_dash = (x >= DASH_LO) && (x <= DASH_HI) && !dy[DW-1];
    assign in_road = (x >= RL_X) && (x < RR_X);
    assign in_edge = ((x >= RL_X) && (x < EL_X)) || ((x >= ER_X) && (x < RR_X));

    always_comb begin
        pix = C_GRASS;
        if (!in_act)      pix = C_BLACK;
        else if (in_car)  pix = C_RED;
        else if (in_dash) pix = C_YELLOW;
        else if (in_edge) pix = C_WHITE;
        else if (in_road) pix = C_ROAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            scroll     <= '0;
            car_x      <= CENTRE[WIDTH-1:0];
            crash_cnt  <= '0;
            frame_tick <= 1'b0;
            crash      <= 1'b0;
            pix_q      <= C_BLACK;
        end else begin
            state      <= state_nx;
            scroll     <= scroll_nx;
            car_x      <= car_x_nx;
            crash_cnt  <= crash_cnt_nx;
            frame_tick <= tick_cond;
            crash      <= (state_nx == CRASH);
            pix_q      <= pix;
        end
    end

    assign vgaRed   = pix_q.r;
    assign vgaGreen = pix_q.g;
    assign vgaBlue  = pix_q.b;
endmodule

// File: tb/tb_road_renderer.sv
// Directed bench for road_renderer: raster colours, frame tick, scroll, steering, crash, reset.
module tb_road_renderer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hor_pix, ver_pix;
    logic       btn_left, btn_right, btn_start;
    logic [1:0] speed;
    logic [3:0] vgaRed, vgaGreen, vgaBlue;
    logic       frame_tick, crash;
    logic [11:0] rgb;

    int n_cmp = 0;
    int n_err = 0;

    road_renderer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hor_pix    (hor_pix),
        .ver_pix    (ver_pix),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_start  (btn_start),
        .speed      (speed),
        .vgaRed     (vgaRed),
        .vgaGreen   (vgaGreen),
        .vgaBlue    (vgaBlue),
        .frame_tick (frame_tick),
        .crash      (crash)
    );

    always #5 clk = ~clk;
    assign rgb = {vgaRed, vgaGreen, vgaBlue};

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic px(input int x, input int y);
        @(negedge clk);
        hor_pix = 10'(x);
        ver_pix = 10'(y);
        @(posedge clk);
        #1;
    endtask

    task automatic pchk(input string tag, input int x, input int y, input logic [11:0] exp);
        px(x, y);
        chk(tag, rgb, exp);
    endtask

    task automatic do_tick();
        px(0, 480);
        chk("tick_hi", {11'd0, frame_tick}, 12'd1);
        px(1, 480);
        chk("tick_lo", {11'd0, frame_tick}, 12'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        hor_pix = '0; ver_pix = '0;
        btn_left = 0; btn_right = 0; btn_start = 0; speed = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rgb", rgb, 12'h000);
        chk("rst_tick", {11'd0, frame_tick}, 12'd0);
        chk("rst_crash", {11'd0, crash}, 12'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // raster colours and 1-clk latency
        pchk("grass", 100, 100, 12'h080);
        @(negedge clk);
        hor_pix = 10'd300; ver_pix = 10'd100;
        #1;
        chk("latency_old", rgb, 12'h080);
        @(posedge clk);
        #1;
        chk("latency_new", rgb, 12'h666);
        pchk("edge_l", 201, 10, 12'hFFF);
        pchk("edge_r", 437, 10, 12'hFFF);
        pchk("blank", 700, 10, 12'h000);
        pchk("dash0", 320, 10, 12'hFF0);
        pchk("dash0_gap", 320, 40, 12'h666);
        pchk("car_l", 304, 401, 12'hF00);
        pchk("car_l_out", 303, 401, 12'h666);
        pchk("car_r", 335, 401, 12'hF00);
        pchk("car_r_out", 336, 401, 12'h666);

        // frame tick in IDLE: nothing moves even with speed set
        speed = 2'd3;
        px(639, 479);
        chk("pretick", {11'd0, frame_tick}, 12'd0);
        do_tick();
        do_tick();
        pchk("idle_scroll", 320, 0, 12'hFF0);
        pchk("idle_car", 304, 401, 12'hF00);
        chk("idle_crash", {11'd0, crash}, 12'd0);

        // start, then 11 frames at 6 px/frame -> scroll 2
        btn_start = 1;
        repeat (3) px(10, 10);
        do_tick();
        btn_start = 0;
        repeat (3) px(10, 10);
        for (int i = 0; i < 11; i++) do_tick();
        pchk("scr2_y1", 320, 1, 12'h666);
        pchk("scr2_y2", 320, 2, 12'hFF0);
        pchk("scr2_y33", 320, 33, 12'hFF0);
        pchk("scr2_y34", 320, 34, 12'h666);
        do_tick();
        pchk("scr8_y7", 320, 7, 12'h666);
        pchk("scr8_y8", 320, 8, 12'hFF0);

        // steer right toward the edge
        speed = 2'd0;
        btn_right = 1;
        repeat (3) px(10, 10);
        for (int i = 0; i < 10; i++) do_tick();
        pchk("car344", 344, 401, 12'hF00);
        btn_left = 1;
        repeat (3) px(10, 10);
        do_tick();
        do_tick();
        pchk("both_l", 344, 401, 12'hF00);
        pchk("both_l_out", 343, 401, 12'h666);
        btn_left = 0;
        repeat (3) px(10, 10);
        for (int i = 0; i < 16; i++) do_tick();
        chk("no_crash408", {11'd0, crash}, 12'd0);
        pchk("car408", 408, 401, 12'hF00);
        pchk("car408_out", 407, 401, 12'h666);
        pchk("car408_r", 439, 401, 12'hF00);
        do_tick();
        chk("crash27", {11'd0, crash}, 12'd1);
        pchk("car412", 412, 401, 12'hF00);
        pchk("car412_out", 411, 401, 12'h666);
        pchk("car412_r", 443, 401, 12'hF00);

        // crash flash and recovery; start is ignored while crashed
        btn_right = 0;
        btn_start = 1;
        for (int i = 1; i <= 60; i++) begin
            do_tick();
            if (i == 7)  pchk("flash7", 413, 401, 12'hF00);
            if (i == 8)  pchk("flash8", 413, 401, 12'h666);
            if (i == 15) pchk("flash15", 413, 401, 12'h666);
            if (i == 16) pchk("flash16", 413, 401, 12'hF00);
            if (i == 59) chk("crash59", {11'd0, crash}, 12'd1);
            if (i == 60) chk("crash60", {11'd0, crash}, 12'd0);
        end
        pchk("rec_car", 304, 401, 12'hF00);
        pchk("rec_old", 412, 401, 12'h666);
        pchk("rec_scroll", 320, 0, 12'hFF0);

        // back to RUN, then reset mid-frame
        btn_right = 1;
        speed = 2'd3;
        do_tick();
        btn_start = 0;
        do_tick();
        pchk("run_car308", 308, 401, 12'hF00);
        pchk("run_mid", 320, 240, 12'h666);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rgb", rgb, 12'h000);
        chk("arst_crash", {11'd0, crash}, 12'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pchk("arst_car", 304, 401, 12'hF00);
        pchk("arst_car_out", 303, 401, 12'h666);
        pchk("arst_scroll", 320, 0, 12'hFF0);
        repeat (3) px(10, 10);
        do_tick();
        pchk("arst_idle_car", 336, 401, 12'h666);
        pchk("arst_idle_scr", 320, 0, 12'hFF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/road_renderer.md
Name: road_renderer

Overview:
- Pixel-colour generator for the Road Fighter display path. It sits directly upstream of the VGA timing driver and is clocked by that driver's pixel clock.
- Consumes the driver's hor_pix/ver_pix counters and returns vgaRed/vgaGreen/vgaBlue.
- Draws grass, road, edge lines, a scrolling centre dash and the player car.
- Owns the per-frame game state: scroll offset, car position, and the IDLE/RUN/CRASH FSM.

Parameters:
WIDTH, 10, pixel-counter width
HACTIVE, 640, active columns
VACTIVE, 480, active rows
ROAD_L, 200, first road column (inclusive)
ROAD_R, 440, last road column + 1 (exclusive)
EDGE_W, 4, edge-line width in pixels, drawn inside the road
CAR_W, 32, car width
CAR_H, 48, car height
CAR_Y, 400, car top row (fixed)
STEP, 4, car x movement per frame while a button is held
DASH_P, 64, dash period in rows (power of two)
CRASH_FRAMES, 60, frames spent in CRASH

Ports:
clk  in  1  pixel clock (25 MHz pixel_clock from the VGA driver)
rst_n  in  1  asynchronous, active-low reset
hor_pix  in  WIDTH  current column from the driver
ver_pix  in  WIDTH  current row from the driver
btn_left  in  1  raw, asynchronous button
btn_right  in  1  raw, asynchronous button
btn_start  in  1  raw, asynchronous button
speed  in  2  scroll rate; 2*speed px per frame
vgaRed  out  4  pixel colour
vgaGreen  out  4  pixel colour
vgaBlue  out  4  pixel colour
frame_tick  out  1  one-cycle pulse at frame boundary
crash  out  1  high while FSM is in CRASH

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values:
  - all colour outputs 0
  - frame_tick 0, crash 0
  - state IDLE
  - scroll 0
  - car_x CENTRE = (ROAD_L+ROAD_R-CAR_W)/2 = 304
  - crash_cnt 0
  - button synchronisers 0
- Reset mid-frame: everything clears immediately; rendering resumes on the first clk after rst_n deasserts, with no frame resync needed.
- Buttons: each passes through a 2-flop synchroniser. Only the synchronised values are used.
- frame_tick:
  - Registered pulse, high for exactly one cycle after the edge where hor_pix==0 && ver_pix==VACTIVE (first blanking line).
  - All game-state updates happen only on that same edge (tick_cond); nothing changes mid-frame.
- Colour latency: exactly 1 clk.
  - Colour registered at edge k reflects the hor_pix/ver_pix sampled at edge k.
  - This matches the driver's registered video-enable stage.
  - Outside the active area (hor_pix>=HACTIVE or ver_pix>=VACTIVE), colour = 0.
- Colour priority (highest first), RGB given as 4-bit values:
  - car: red F,0,0
    - region: car_x <= x < car_x+CAR_W and CAR_Y <= y < CAR_Y+CAR_H
    - in CRASH the car is drawn only when crash_cnt[3]==0 (flash)
  - centre dash: yellow F,F,0
    - |x - (ROAD_L+ROAD_R)/2| < 2 and ((y - scroll) mod DASH_P) < DASH_P/2
    - use log2(DASH_P)-bit wrap-around subtraction
  - edge: white F,F,F
    - x in [ROAD_L, ROAD_L+EDGE_W) or [ROAD_R-EDGE_W, ROAD_R)
  - road: grey 6,6,6 for ROAD_L <= x < ROAD_R
  - grass: green 0,8,0 otherwise
- FSM, transitions only at tick_cond:
  - IDLE:
    - scroll and car frozen
    - on btn_start → RUN, with car_x = CENTRE and scroll = 0
  - RUN:
    - scroll <= scroll + 2*speed, mod DASH_P (wraps, no saturation)
    - next_x:
      - left only: max(car_x-STEP, 0)
      - right only: min(car_x+STEP, HACTIVE-CAR_W)
      - both or neither: car_x
    - car_x <= next_x
    - if next_x < ROAD_L or next_x+CAR_W > ROAD_R → CRASH, crash_cnt = 0
  - CRASH:
    - scroll frozen, car_x frozen
    - crash_cnt increments each tick
    - when crash_cnt == CRASH_FRAMES-1 → IDLE, with car_x = CENTRE and scroll = 0
    - btn_start is ignored
- crash: registered, equals (state==CRASH).
- Width rules: x+CAR_W and the clamp arithmetic are evaluated at WIDTH+1 bits, so there is no wrap.

Decomposition:
- Package road_pkg holds:
  - state enum (IDLE, RUN, CRASH)
  - colour constants
  - VGA active/total timing constants, shared with the VGA driver
- One sub-module: btn_sync, a 2-flop synchroniser parameterised by width, instantiated once for the 3 buttons.
- Colour mux and FSM stay in road_renderer.

Test Plan:
1. Reset and raster: after rst_n release, no buttons, sweep a full 800x525 raster.
   - (x=100, y=100) → 0,8,0
   - (x=300, y=100) → 6,6,6
   - (x=201, y=10) → F,F,F
   - (x=700, y=10) → 0
   - colour appears 1 clk after the coordinates are presented
2. Frame tick: frame_tick pulses exactly once per frame, 1 cycle wide, after (0,480). State is unchanged in IDLE.
3. Start and scroll: btn_start held for 1 frame, speed=3, then 11 ticks.
   - state RUN
   - scroll = 66 mod 64 = 2
   - centre dash rows shift down by 6 per frame
4. Steering to crash: in RUN, hold btn_right from car_x=304.
   - car_x reaches 408 after 26 ticks with no crash
   - tick 27 → car_x=412, crash=1
   - holding left and right together moves nothing
5. Crash recovery: after a crash, count ticks.
   - car pixels at (car_x+1, 401) alternate red/road every 8 frames
   - crash falls after 60 ticks, state IDLE, car_x=304
   - btn_start during CRASH is ignored
6. Async reset mid-frame: assert rst_n=0 at (320,240) during RUN.
   - outputs 0 the same cycle
   - state IDLE, scroll=0, car_x=304
